// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the IF/MEM SRAM arbiter.
package sram_arb_pkg;
  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, IF_RD, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  localparam int DEF_DATA_BASE   = 1024;
  localparam int DEF_WAIT_CYCLES = 5;

  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles) + 1;
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// SRAM wait-state down-counter: load sets WAIT_CYCLES-1, dec counts toward 0, zero flags expiry.
module sram_wait_counter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(WAIT_CYCLES - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM shared by fetch and memory stage; MEM has priority, no preemption.
// Optional one-entry fetch buffer when SRAM_ARB_IF_BUF_EN is defined.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int DATA_BASE   = DEF_DATA_BASE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [LEN-1:0]    if_addr,
  output logic [LEN-1:0]    if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [LEN-1:0]    mem_addr,
  input  logic [LEN-1:0]    mem_wdata,
  output logic [LEN-1:0]    mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LEN-1:0]    sram_wdata,
  input  logic [LEN-1:0]    sram_rdata,
  output logic              sram_we_n,
  output logic              sram_ce_n
);
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [LEN-1:0]    sram_wdata_q, sram_wdata_d;
  logic              we_n_q, we_n_d, ce_n_q, ce_n_d;
  logic              if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
  logic [LEN-1:0]    if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              mem_req, buf_hit;
  logic [LEN-1:0]    mem_off, buf_dat;
  logic [ADDR_W-1:0] mem_word, if_word;
  logic              unused_addr_bits;

  // Data space is rebased to SRAM word 0; byte offset bits are dropped.
  assign mem_off  = mem_addr - LEN'(DATA_BASE);
  assign mem_word = mem_off[ADDR_W+1:2];
  assign if_word  = if_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_off[LEN-1:ADDR_W+2], mem_off[1:0],
                              if_addr[LEN-1:ADDR_W+2], if_addr[1:0]};

  assign mem_req = mem_r_en | mem_w_en;
  assign freeze  = mem_req & ~mem_ready_q;

`ifdef SRAM_ARB_IF_BUF_EN
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_word_q, buf_word_d;
  logic [LEN-1:0]    buf_dat_q, buf_dat_d;

  assign buf_hit = buf_vld_q && (buf_word_q == if_word);
  assign buf_dat = buf_dat_q;

  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_word_d = buf_word_q;
    buf_dat_d  = buf_dat_q;
    if (state_q == IDLE && mem_w_en && mem_word == buf_word_q) begin
      buf_vld_d = 1'b0;
    end else if (state_q == IF_RD && cnt_zero) begin
      buf_vld_d  = 1'b1;
      buf_word_d = sram_addr_q;
      buf_dat_d  = sram_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld_q  <= 1'b0;
      buf_word_q <= '0;
      buf_dat_q  <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_word_q <= buf_word_d;
      buf_dat_q  <= buf_dat_d;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign buf_dat = '0;
`endif

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = we_n_q;
    ce_n_d       = ce_n_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          // A simultaneous read+write request is served as a write.
          state_d      = mem_w_en ? MEM_WR : MEM_RD;
          owner_d      = OWN_MEM;
          sram_addr_d  = mem_word;
          sram_wdata_d = mem_wdata;
          we_n_d       = ~mem_w_en;
          ce_n_d       = 1'b0;
          cnt_load     = 1'b1;
        end else if (if_req && buf_hit) begin
          state_d    = DONE;
          owner_d    = OWN_IF;
          if_ready_d = 1'b1;
          if_rdata_d = buf_dat;
        end else if (if_req) begin
          state_d     = IF_RD;
          owner_d     = OWN_IF;
          sram_addr_d = if_word;
          we_n_d      = 1'b1;
          ce_n_d      = 1'b0;
          cnt_load    = 1'b1;
        end
      end
      MEM_RD, MEM_WR, IF_RD: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (owner_q == OWN_MEM) begin
            mem_ready_d = 1'b1;
            if (state_q == MEM_RD) mem_rdata_d = sram_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = sram_rdata;
          end
        end
      end
      // Turnaround cycle so a still-held request is not served twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      ce_n_q       <= 1'b1;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      ce_n_q       <= ce_n_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_ce_n  = ce_n_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM; covers SRAM_ARB_IF_BUF_EN builds too.
module tb_sram_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, freeze, sram_we_n, sram_ce_n;
  logic [16:0] sram_addr;
  logic        tb_init;
  logic [31:0] sram [64];
  int          errors = 0;
  int          checks = 0;

`ifdef SRAM_ARB_IF_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  always #5 clock = ~clock;

  sram_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n)
  );

  always @(posedge clock) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= 32'hA000_0000 + i;
      sram[2] <= 32'hDEAD_BEEF;
    end else if (!sram_ce_n && !sram_we_n) begin
      sram[sram_addr[5:0]] <= sram_wdata;
    end
  end
  assign sram_rdata = sram[sram_addr[5:0]];

  typedef struct {
    logic        rd, wr, ifr;
    logic [31:0] addr, wdata, if_addr;
    int          lat;
    logic        chk_rd;
    logic [31:0] rdata;
    int          n_ce, n_we, n_frz;
    logic [16:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic ifr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] ia, input int lat,
                     input logic chk_rd, input logic [31:0] rdata, input int n_ce,
                     input int n_we, input int n_frz, input logic [16:0] word);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ifr = ifr; v.addr = addr; v.wdata = wdata; v.if_addr = ia;
    v.lat = lat; v.chk_rd = chk_rd; v.rdata = rdata; v.n_ce = n_ce; v.n_we = n_we;
    v.n_frz = n_frz; v.word = word;
    vecs.push_back(v);
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
  task automatic run_vec(input vec_t v, input string name);
    int lat, n_ce, n_we, n_frz, bad;
    logic [31:0] rd;
    logic rdy;
    lat = -1; n_ce = 0; n_we = 0; n_frz = 0; bad = 0; rd = '0;
    mem_r_en = v.rd; mem_w_en = v.wr; if_req = v.ifr;
    mem_addr = v.addr; mem_wdata = v.wdata; if_addr = v.if_addr;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!sram_ce_n) begin
        n_ce++;
        if (sram_addr !== v.word) bad++;
      end
      if (!sram_we_n) n_we++;
      if (freeze) n_frz++;
      rdy = v.ifr ? if_ready : mem_ready;
      if (rdy) begin
        lat = c;
        rd  = v.ifr ? if_rdata : mem_rdata;
        break;
      end
      @(posedge clock); #1;
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0; if_req = 1'b0;
    @(posedge clock); #1;
    chk({name, "_latency"}, lat, v.lat);
    if (v.chk_rd) chk({name, "_rdata"}, rd, v.rdata);
    chk({name, "_ce_cycles"}, n_ce, v.n_ce);
    chk({name, "_we_cycles"}, n_we, v.n_we);
    chk({name, "_freeze_cycles"}, n_frz, v.n_frz);
    chk({name, "_addr_held"}, bad, 0);
  endtask

  initial begin
    int mlat, ilat, nrdy;
    logic [31:0] mrd, ird;
    vec_t v;

    reset = 1'b1; tb_init = 1'b1;
    if_req = 0; mem_r_en = 0; mem_w_en = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;

    //  rd wr if  addr   wdata         if_addr lat         chk rdata         ce          we frz word
    add(1, 0, 0, 1032, 0,             0,      6,           1, 32'hDEADBEEF, 5,          0, 6, 2);
    add(0, 1, 0, 1028, 32'h12345678, 0,      6,           0, 0,            5,          5, 6, 1);
    add(1, 0, 0, 1028, 0,             0,      6,           1, 32'h12345678, 5,          0, 6, 1);
    add(0, 0, 1, 0,    0,             8,      6,           1, 32'hDEADBEEF, 5,          0, 0, 2);
    add(0, 0, 1, 0,    0,             32'h13, 6,           1, 32'hA0000004, 5,          0, 0, 4);
    add(1, 1, 0, 1036, 32'hCAFEF00D, 0,      6,           0, 0,            5,          5, 6, 3);
    add(1, 0, 0, 1036, 0,             0,      6,           1, 32'hCAFEF00D, 5,          0, 6, 3);
    add(0, 0, 1, 0,    0,             12,     6,           1, 32'hCAFEF00D, 5,          0, 0, 3);
    add(0, 0, 1, 0,    0,             4,      6,           1, 32'h12345678, 5,          0, 0, 1);
    add(0, 0, 1, 0,    0,             4,      BUF ? 1 : 6, 1, 32'h12345678, BUF ? 0 : 5, 0, 0, 1);
    add(0, 1, 0, 1028, 32'h55AA55AA, 0,      6,           0, 0,            5,          5, 6, 1);
    add(0, 0, 1, 0,    0,             4,      6,           1, 32'h55AA55AA, 5,          0, 0, 1);

    repeat (3) @(posedge clock);
    #1; tb_init = 1'b0;
    #1;
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_freeze", freeze, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_vec(v, $sformatf("vec%0d", i));
    end

    // Simultaneous fetch and load: load first, fetch sampled in the IDLE after its DONE.
    mlat = -1; ilat = -1; mrd = '0; ird = '0;
    mem_r_en = 1; mem_addr = 1024; if_req = 1; if_addr = 8;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_ready && mlat < 0) begin mlat = c; mrd = mem_rdata; mem_r_en = 0; end
      if (if_ready && ilat < 0) begin ilat = c; ird = if_rdata; if_req = 0; end
      if (mlat >= 0 && ilat >= 0) break;
      @(posedge clock); #1;
    end
    mem_r_en = 0; if_req = 0;
    @(posedge clock); #1;
    chk("simul_mem_latency", mlat, 6);
    chk("simul_mem_rdata", mrd, 32'hA0000000);
    chk("simul_if_latency", ilat, 13);
    chk("simul_if_rdata", ird, 32'hDEADBEEF);

    // Reset in the third access cycle of a load abandons it.
    mem_r_en = 1; mem_addr = 1032;
    repeat (3) begin @(posedge clock); #1; end
    #1;
    chk("rstmid_ce_active", sram_ce_n, 0);
    reset = 1'b1; mem_r_en = 0;
    @(posedge clock); #2;
    chk("rstmid_ce_n", sram_ce_n, 1);
    chk("rstmid_sram_addr", sram_addr, 0);
    chk("rstmid_mem_ready", mem_ready, 0);
    chk("rstmid_mem_rdata", mem_rdata, 0);
    reset = 1'b0;
    nrdy = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #2;
      if (mem_ready || if_ready) nrdy++;
    end
    chk("rstmid_no_ready", nrdy, 0);
    @(posedge clock); #1;
    v = vecs[0];
    run_vec(v, "post_reset_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
